// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner/emulator pair: FSM encoding,
// matrix geometry and keyCode field layout.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int CODE_W   = 5;
    localparam int ROW_LSB  = 2;
    localparam int COL_LSB  = 0;

    localparam logic [CODE_W-1:0] KEY_NONE = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_e;

    function automatic logic key_valid(input logic [CODE_W-1:0] code);
        return (code < KEY_NONE);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_matrix_emu_if.sv
// Press-command handshake between a requester (master) and the keypad emulator (slave).
interface keypad_matrix_emu_if;
    import keypad_pkg::*;

    logic              pressReq;
    logic [CODE_W-1:0] keyCode;
    logic              pressAck;
    logic              busy;
    logic [CODE_W-1:0] pressedKey;

    modport master (output pressReq, keyCode, input pressAck, busy, pressedKey);
    modport slave  (input pressReq, keyCode, output pressAck, busy, pressedKey);

endinterface

// File: rtl/keypad_phase_timer.sv
// Shared phase down-counter: loads (length-1) on phase entry, flags zero at phase end.
module keypad_phase_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o,
    output logic         nxt_lsb_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o    = (cnt_q == '0);
    assign nxt_lsb_o = cnt_d[0];

endmodule

// File: rtl/keypad_matrix_emu.sv
// 4x4 keypad switch-matrix emulator: closes one contact per press command.
// Contact chatter on press/release is built only with KEYPAD_EMU_BOUNCE_EN.
module keypad_matrix_emu
    import keypad_pkg::*;
#(
    parameter int HOLD_CYC   = 16,
    parameter int BOUNCE_CYC = 4,
    parameter int GAP_CYC    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [KEY_COLS-1:0] keyCols,
    output logic [KEY_ROWS-1:0] keyRows,
    keypad_matrix_emu_if.slave  cmd
);

    localparam int MAX_LEN = max3(HOLD_CYC, BOUNCE_CYC, GAP_CYC);
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

    if (HOLD_CYC < 1 || BOUNCE_CYC < 1 || GAP_CYC < 1) begin : g_bad_param
        $error("keypad_matrix_emu: phase lengths must be nonzero");
    end

    state_e            state_q, state_d;
    logic              contact_q, contact_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] pk_q, pk_d;
    logic              accept, load, tmr_zero, cnt_lsb;
    logic [CW-1:0]     load_val;

    keypad_phase_timer #(.W(CW)) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load_i    (load),
        .value_i   (load_val),
        .zero_o    (tmr_zero),
        .nxt_lsb_o (cnt_lsb)
    );

    assign accept = cmd.pressReq && (state_q == ST_IDLE);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CW-1:0] BOUNCE_LD  = CW'(BOUNCE_CYC - 1);
    // Parity of the cycle index within a bounce phase; chatter starts closed on press.
    logic phase_odd;
    assign phase_odd = cnt_lsb ^ BOUNCE_LD[0];
`else
    logic unused_cnt_lsb;
    assign unused_cnt_lsb = cnt_lsb;
`endif

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                load = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                state_d  = ST_BOUNCE_IN;
                load_val = BOUNCE_LD;
`else
                state_d  = ST_HOLD;
                load_val = HOLD_LD;
`endif
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_BOUNCE_IN: if (tmr_zero) begin
                state_d  = ST_HOLD;
                load     = 1'b1;
                load_val = HOLD_LD;
            end
            ST_HOLD: if (tmr_zero) begin
                state_d  = ST_BOUNCE_OUT;
                load     = 1'b1;
                load_val = BOUNCE_LD;
            end
            ST_BOUNCE_OUT: if (tmr_zero) begin
                state_d  = ST_GAP;
                load     = 1'b1;
                load_val = GAP_LD;
            end
`else
            ST_HOLD: if (tmr_zero) begin
                state_d  = ST_GAP;
                load     = 1'b1;
                load_val = GAP_LD;
            end
`endif
            ST_GAP: if (tmr_zero) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Contact and pressedKey are computed from next state so they line up with state_q.
    always_comb begin
        contact_d = 1'b0;
        case (state_d)
            ST_HOLD:       contact_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_BOUNCE_IN:  contact_d = ~phase_odd;
            ST_BOUNCE_OUT: contact_d = phase_odd;
`endif
            default:       contact_d = 1'b0;
        endcase
        code_d = accept ? cmd.keyCode : code_q;
        pk_d   = (contact_d && key_valid(code_d)) ? code_d : KEY_NONE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            contact_q <= 1'b0;
            code_q    <= KEY_NONE;
            pk_q      <= KEY_NONE;
        end else begin
            state_q   <= state_d;
            contact_q <= contact_d;
            code_q    <= code_d;
            pk_q      <= pk_d;
        end
    end

    // Zero-latency path from column drive to row sense, like a real switch.
    always_comb begin
        keyRows = '0;
        if (contact_q && key_valid(code_q))
            keyRows[code_q[ROW_LSB +: 2]] = keyCols[code_q[COL_LSB +: 2]];
    end

    assign cmd.pressAck   = accept && !RST;
    assign cmd.busy       = (state_q != ST_IDLE);
    assign cmd.pressedKey = pk_q;

endmodule
